// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC flit-type definitions and head-field layout helper
// Contents: flit_type_t (INVALID/HEAD/BODY/TAIL), head_field_lsb() giving the
// bit offset of the destination or source field inside a head payload.
package noc_pkg;

    typedef enum logic [1:0] {
        FLIT_INVALID = 2'd0,
        FLIT_HEAD    = 2'd1,
        FLIT_BODY    = 2'd2,
        FLIT_TAIL    = 2'd3
    } flit_type_t;

    // Head payload layout: destination in the low DEST_W bits, source directly above.
    function automatic int head_field_lsb(input int dest_w, input bit is_src);
        return is_src ? dest_w : 0;
    endfunction

endpackage

// File: rtl/ni_packetizer_if.sv
// rtl/ni_packetizer_if.sv - core request/payload and router link handshake bundle
// Signals: req_valid/req_ready/req_dest (packet request), pl_valid/pl_ready/pl_data
// (payload words), data_out/valid_out/ready_out (flit link to router input port).
// slave = packetizer side, master = core/router side.
interface ni_packetizer_if #(
    parameter int DEST_W     = 7,
    parameter int PL_W       = 30,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [DEST_W-1:0]     req_dest;
    logic                  pl_valid;
    logic                  pl_ready;
    logic [PL_W-1:0]       pl_data;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ready_out;

    modport slave (
        input  req_valid, req_dest, pl_valid, pl_data, ready_out,
        output req_ready, pl_ready, data_out, valid_out
    );

    modport master (
        output req_valid, req_dest, pl_valid, pl_data, ready_out,
        input  req_ready, pl_ready, data_out, valid_out
    );
endinterface

// File: rtl/flit_out_reg.sv
// rtl/flit_out_reg.sv - single-entry valid/ready output register for a flit link
// Ports: clk, rst (sync, active-low), load/load_data (new flit, only when adv),
// ready_out (downstream accept), adv (register may take a new flit this cycle),
// data_out/valid_out (registered link outputs).
module flit_out_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready_out,
    output logic             adv,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // The register is free when empty or when its current flit leaves this cycle.
    assign adv = !valid_q || ready_out;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (adv) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
endmodule

// File: rtl/ni_packetizer.sv
// rtl/ni_packetizer.sv - NI transmitter turning {dest, payload} messages into head/body/tail flits
// Ports: clk, rst (sync, active-low), nif (slave: request, payload and router link),
// dest_err (1-cycle pulse on dropped out-of-range request), pkt_sent (wrapping count
// of tails accepted by the router), busy (packet in progress or flit pending).
module ni_packetizer
    import noc_pkg::*;
#(
    parameter int N             = 100,
    parameter int INDEX         = 1,
    parameter int DATA_WIDTH    = 32,
    parameter int TYPE_WIDTH    = 2,
    parameter int FlitPerPacket = 6,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ni_packetizer_if.slave       nif,
    output logic                 dest_err,
    output logic [CNT_WIDTH-1:0] pkt_sent,
    output logic                 busy
);
    localparam int DEST_W  = (N > 1) ? $clog2(N) : 1;
    localparam int PL_W    = DATA_WIDTH - TYPE_WIDTH;
    localparam int CW      = $clog2(FlitPerPacket);
    localparam int DEST_LSB = head_field_lsb(DEST_W, 1'b0);
    localparam int SRC_LSB  = head_field_lsb(DEST_W, 1'b1);

    localparam logic [0:0]    S_IDLE    = 1'b0;
    localparam logic [0:0]    S_PAYLOAD = 1'b1;
    localparam logic [CW-1:0] LAST_BODY = CW'(FlitPerPacket - 2);
    localparam logic [31:0]   N_U       = N;

    logic [0:0]           state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 dest_err_q, dest_err_d;
    logic [CNT_WIDTH-1:0] pkt_sent_q, pkt_sent_d;

    logic                  adv;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_data;
    logic [PL_W-1:0]       head_pl;
    logic                  dest_ok;
    logic                  tail_accept;

    assign dest_ok = ({{(32-DEST_W){1'b0}}, nif.req_dest} < N_U);

    always_comb begin
        head_pl = '0;
        head_pl[DEST_LSB +: DEST_W] = nif.req_dest;
        head_pl[SRC_LSB  +: DEST_W] = DEST_W'(INDEX);
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        dest_err_d    = 1'b0;
        load          = 1'b0;
        load_data     = '0;
        nif.req_ready = 1'b0;
        nif.pl_ready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Handshakes are held off while reset is asserted.
                nif.req_ready = rst && adv;
                if (nif.req_valid && nif.req_ready) begin
                    if (dest_ok) begin
                        load      = 1'b1;
                        load_data = {TYPE_WIDTH'(FLIT_HEAD), head_pl};
                        count_d   = '0;
                        state_d   = S_PAYLOAD;
                    end else begin
                        dest_err_d = 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                nif.pl_ready = rst && adv;
                if (nif.pl_valid && nif.pl_ready) begin
                    load    = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q < LAST_BODY) begin
                        load_data = {TYPE_WIDTH'(FLIT_BODY), nif.pl_data};
                    end else begin
                        load_data = {TYPE_WIDTH'(FLIT_TAIL), nif.pl_data};
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    flit_out_reg #(
        .WIDTH (DATA_WIDTH)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .ready_out (nif.ready_out),
        .adv       (adv),
        .data_out  (nif.data_out),
        .valid_out (nif.valid_out)
    );

    assign tail_accept = nif.valid_out && nif.ready_out &&
                         (nif.data_out[DATA_WIDTH-1 -: TYPE_WIDTH] == TYPE_WIDTH'(FLIT_TAIL));
    assign pkt_sent_d  = pkt_sent_q + CNT_WIDTH'(tail_accept);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            dest_err_q <= 1'b0;
            pkt_sent_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            dest_err_q <= dest_err_d;
            pkt_sent_q <= pkt_sent_d;
        end
    end

    assign dest_err = dest_err_q;
    assign pkt_sent = pkt_sent_q;
    assign busy     = (state_q != S_IDLE) || nif.valid_out;
endmodule
